// File: rtl/pkt_readout_ctrl.sv
// Packet readout controller: captures a 64-bit packet from the shift buffer
// and presents it to an SPI slave one byte per chip-select cycle.
module pkt_readout_ctrl #(
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       pkt_rec,
  input  logic       cs_sync,
  input  logic       stat_clr,
  output logic       pkt_ld,
  output logic       pkt_rst,
  output logic       spi_ld,
  output logic [2:0] byte_sel,
  output logic [3:0] bytes_left,
  output logic       pkt_avail,
  output logic       overrun,
  output logic       tmo
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_XFER    = 2'd3;
  localparam logic [15:0] TMO_LAST  = 16'(TMO_CYC - 1);

  logic [1:0]  r_state;
  logic        r_pkt_prev;
  logic [15:0] r_tmo_cnt;

  logic w_rise;
  logic w_ovr_set;
  logic w_tmo_hit;
  logic w_last_byte;

  assign w_rise      = pkt_rec & ~r_pkt_prev;
  assign w_ovr_set   = w_rise & rx_en & (r_state != ST_IDLE);
  assign w_tmo_hit   = rx_en & (r_state == ST_PRESENT) & cs_sync & (r_tmo_cnt == TMO_LAST);
  assign w_last_byte = (bytes_left <= 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_prev <= 1'b0;
      overrun    <= 1'b0;
      tmo        <= 1'b0;
    end else begin
      r_pkt_prev <= pkt_rec;
      // A set event in the same cycle as stat_clr wins.
      if (w_ovr_set)     overrun <= 1'b1;
      else if (stat_clr) overrun <= 1'b0;
      if (w_tmo_hit)     tmo <= 1'b1;
      else if (stat_clr) tmo <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tmo_cnt  <= 16'd0;
      pkt_ld     <= 1'b0;
      pkt_rst    <= 1'b0;
      spi_ld     <= 1'b0;
      byte_sel   <= 3'd0;
      bytes_left <= 4'd0;
      pkt_avail  <= 1'b0;
    end else begin
      pkt_ld  <= 1'b0;
      pkt_rst <= 1'b0;
      spi_ld  <= 1'b0;
      if (!rx_en) begin
        r_state    <= ST_IDLE;
        r_tmo_cnt  <= 16'd0;
        byte_sel   <= 3'd0;
        bytes_left <= 4'd0;
        pkt_avail  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              pkt_ld  <= 1'b1;
              r_state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            pkt_rst    <= 1'b1;
            spi_ld     <= 1'b1;
            byte_sel   <= 3'd0;
            bytes_left <= 4'd8;
            pkt_avail  <= 1'b1;
            r_tmo_cnt  <= 16'd0;
            r_state    <= ST_PRESENT;
          end
          ST_PRESENT: begin
            if (!cs_sync) begin
              r_tmo_cnt <= 16'd0;
              r_state   <= ST_XFER;
            end else if (w_tmo_hit) begin
              r_tmo_cnt  <= 16'd0;
              byte_sel   <= 3'd0;
              bytes_left <= 4'd0;
              pkt_avail  <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
          end
          ST_XFER: begin
            // CS held low keeps us here indefinitely; no timeout while a byte is in flight.
            if (cs_sync) begin
              if (w_last_byte) begin
                byte_sel   <= 3'd0;
                bytes_left <= 4'd0;
                pkt_avail  <= 1'b0;
                r_state    <= ST_IDLE;
              end else begin
                byte_sel   <= byte_sel + 3'd1;
                bytes_left <= bytes_left - 4'd1;
                spi_ld     <= 1'b1;
                r_state    <= ST_PRESENT;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_readout_ctrl.sv
// Directed bench for pkt_readout_ctrl with a short timeout (TMO_CYC=16).
module tb_pkt_readout_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_en = 1'b0;
  logic       pkt_rec = 1'b0;
  logic       cs_sync = 1'b1;
  logic       stat_clr = 1'b0;
  logic       pkt_ld, pkt_rst, spi_ld, pkt_avail, overrun, tmo;
  logic [2:0] byte_sel;
  logic [3:0] bytes_left;

  int checks = 0;
  int errors = 0;
  int n_ld = 0, n_rst = 0, n_spi = 0, n_clash = 0;

  pkt_readout_ctrl #(.TMO_CYC(16)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .pkt_rec(pkt_rec), .cs_sync(cs_sync),
    .stat_clr(stat_clr), .pkt_ld(pkt_ld), .pkt_rst(pkt_rst), .spi_ld(spi_ld),
    .byte_sel(byte_sel), .bytes_left(bytes_left), .pkt_avail(pkt_avail),
    .overrun(overrun), .tmo(tmo)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (pkt_ld) n_ld++;
    if (pkt_rst) n_rst++;
    if (spi_ld) n_spi++;
    if (pkt_ld && spi_ld) n_clash++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rise on pkt_rec, then verify the load / capture pulse timing.
  task automatic start_pkt(input string tag);
    pkt_rec = 1'b1;
    tick();
    checks++;
    if (pkt_ld !== 1'b1 || pkt_rst !== 1'b0 || spi_ld !== 1'b0) begin
      errors++;
      $display("FAIL %s_ld got ld=%b rst=%b spi=%b exp ld=1 rst=0 spi=0", tag, pkt_ld, pkt_rst, spi_ld);
    end
    pkt_rec = 1'b0;
    tick();
    checks++;
    if (pkt_ld !== 1'b0 || pkt_rst !== 1'b1 || spi_ld !== 1'b1 || pkt_avail !== 1'b1 ||
        bytes_left !== 4'd8 || byte_sel !== 3'd0) begin
      errors++;
      $display("FAIL %s_cap got ld=%b rst=%b spi=%b av=%b left=%0d sel=%0d exp 0 1 1 1 8 0",
               tag, pkt_ld, pkt_rst, spi_ld, pkt_avail, bytes_left, byte_sel);
    end
    $display("txn %s: packet captured", tag);
  endtask

  // One CS low/high cycle starting in PRESENT.
  task automatic read_byte(input int sel, input int left);
    checks++;
    if (byte_sel !== 3'(sel) || bytes_left !== 4'(left)) begin
      errors++;
      $display("FAIL byte_pre got sel=%0d left=%0d exp sel=%0d left=%0d", byte_sel, bytes_left, sel, left);
    end
    cs_sync = 1'b0;
    tick();
    cs_sync = 1'b1;
    tick();
    checks++;
    if (left == 1) begin
      if (bytes_left !== 4'd0 || byte_sel !== 3'd0 || pkt_avail !== 1'b0 || spi_ld !== 1'b0) begin
        errors++;
        $display("FAIL byte_last got left=%0d sel=%0d av=%b spi=%b exp 0 0 0 0", bytes_left, byte_sel, pkt_avail, spi_ld);
      end
    end else begin
      if (bytes_left !== 4'(left - 1) || byte_sel !== 3'(sel + 1) || pkt_avail !== 1'b1 || spi_ld !== 1'b1) begin
        errors++;
        $display("FAIL byte_next got left=%0d sel=%0d av=%b spi=%b exp %0d %0d 1 1",
                 bytes_left, byte_sel, pkt_avail, spi_ld, left - 1, sel + 1);
      end
    end
    $display("txn byte %0d read, bytes_left now %0d", sel, bytes_left);
  endtask

  task automatic abort_readout();
    rx_en = 1'b0;
    tick();
    rx_en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++;
    if ({pkt_ld, pkt_rst, spi_ld, byte_sel, bytes_left, pkt_avail, overrun, tmo} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {pkt_ld, pkt_rst, spi_ld, byte_sel, bytes_left, pkt_avail, overrun, tmo});
    end
    rst = 1'b1;
    rx_en = 1'b1;
    tick();
    $display("txn reset released");
  endtask

  task automatic test_nominal();
    int ld0, rst0, spi0;
    ld0 = n_ld; rst0 = n_rst; spi0 = n_spi;
    start_pkt("nominal");
    tick();
    for (int i = 0; i < 8; i++) read_byte(i, 8 - i);
    tick();
    checks++;
    if (n_ld - ld0 != 1 || n_rst - rst0 != 1 || n_spi - spi0 != 8) begin
      errors++;
      $display("FAIL nominal_pulses got ld=%0d rst=%0d spi=%0d exp 1 1 8", n_ld - ld0, n_rst - rst0, n_spi - spi0);
    end
  endtask

  task automatic test_overrun();
    int ld0;
    ld0 = n_ld;
    start_pkt("overrun");
    for (int i = 0; i < 3; i++) read_byte(i, 8 - i);
    pkt_rec = 1'b1;
    tick();
    pkt_rec = 1'b0;
    checks++;
    if (overrun !== 1'b1 || pkt_ld !== 1'b0 || bytes_left !== 4'd5 || pkt_avail !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got ovr=%b ld=%b left=%0d av=%b exp 1 0 5 1", overrun, pkt_ld, bytes_left, pkt_avail);
    end
    for (int i = 3; i < 8; i++) read_byte(i, 8 - i);
    checks++;
    if (n_ld - ld0 != 1) begin
      errors++;
      $display("FAIL overrun_ldcount got %0d exp 1", n_ld - ld0);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr got %b exp 0", overrun);
    end
  endtask

  task automatic test_timeout();
    start_pkt("timeout");
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (tmo !== 1'b0 || pkt_avail !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got tmo=%b av=%b exp 0 1", tmo, pkt_avail);
    end
    tick();
    checks++;
    if (tmo !== 1'b1 || pkt_avail !== 1'b0 || bytes_left !== 4'd0 || byte_sel !== 3'd0) begin
      errors++;
      $display("FAIL tmo_fire got tmo=%b av=%b left=%0d sel=%0d exp 1 0 0 0", tmo, pkt_avail, bytes_left, byte_sel);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (tmo !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clr got %b exp 0", tmo);
    end
  endtask

  task automatic test_mode_switch();
    start_pkt("mode");
    for (int i = 0; i < 3; i++) read_byte(i, 8 - i);
    cs_sync = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (tmo !== 1'b0 || pkt_avail !== 1'b1 || bytes_left !== 4'd5) begin
      errors++;
      $display("FAIL xfer_hold got tmo=%b av=%b left=%0d exp 0 1 5", tmo, pkt_avail, bytes_left);
    end
    rx_en = 1'b0;
    tick();
    cs_sync = 1'b1;
    checks++;
    if (bytes_left !== 4'd0 || pkt_avail !== 1'b0 || byte_sel !== 3'd0 || spi_ld !== 1'b0) begin
      errors++;
      $display("FAIL mode_idle got left=%0d av=%b sel=%0d spi=%b exp 0 0 0 0", bytes_left, pkt_avail, byte_sel, spi_ld);
    end
    pkt_rec = 1'b1;
    tick();
    tick();
    checks++;
    if (pkt_ld !== 1'b0 || overrun !== 1'b0 || pkt_rst !== 1'b0) begin
      errors++;
      $display("FAIL mode_ignore got ld=%b ovr=%b rst=%b exp 0 0 0", pkt_ld, overrun, pkt_rst);
    end
    pkt_rec = 1'b0;
    tick();
    rx_en = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    start_pkt("simul");
    pkt_rec = 1'b1;
    stat_clr = 1'b1;
    tick();
    pkt_rec = 1'b0;
    stat_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL simul_priority got %b exp 1", overrun);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul_clear got %b exp 0", overrun);
    end
    abort_readout();
  endtask

  task automatic test_async_reset();
    start_pkt("areset");
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pkt_ld, pkt_rst, spi_ld, byte_sel, bytes_left, pkt_avail, overrun, tmo} !== 13'd0) begin
      errors++;
      $display("FAIL areset_outputs got %b exp 0", {pkt_ld, pkt_rst, spi_ld, byte_sel, bytes_left, pkt_avail, overrun, tmo});
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (pkt_ld !== 1'b0 || spi_ld !== 1'b0 || pkt_avail !== 1'b0) begin
      errors++;
      $display("FAIL areset_quiet got ld=%b spi=%b av=%b exp 0 0 0", pkt_ld, spi_ld, pkt_avail);
    end
    start_pkt("after_reset");
    abort_readout();
  endtask

  task automatic test_no_clash();
    checks++;
    if (n_clash != 0) begin
      errors++;
      $display("FAIL ld_spi_overlap got %0d exp 0", n_clash);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_timeout();
    test_mode_switch();
    test_simultaneous();
    test_async_reset();
    test_no_clash();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
